shift_pipe: RTL and testbench

- Parametrised, pipelined shift execution unit for the RV64I integer datapath.
- Covers SLL/SRL/SRA and the word forms SLLW/SRLW/SRAW.
- Replaces the single-cycle combinational shift helpers with a STAGES-deep pipeline that has valid/ready backpressure, flush and a pass-through tag.
- Sits beside the ALU in EX; results go to the writeback arbiter.

---
 rtl/shift_pipe_pkg.sv | 39 +++
 rtl/shift_pipe_stage_reg.sv | 83 ++++++++
 rtl/shift_pipe.sv | 120 ++++++++++++
 tb/tb_shift_pipe.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pipe_pkg.sv
// Types and helpers shared by the pipelined shift unit.
// The stage helper always works at 64 bits; narrower datapaths extend in and slice out.
package shift_pipe_pkg;

   typedef enum logic [2:0] {
      OpSll  = 3'd0,
      OpSrl  = 3'd1,
      OpSra  = 3'd2,
      OpSllw = 3'd4,
      OpSrlw = 3'd5,
      OpSraw = 3'd6
   } shift_op_e;

   localparam int unsigned MAX_XLEN = 64;

   function automatic int unsigned shamt_w(input int unsigned xlen);
      return $clog2(xlen);
   endfunction

   // amt_bits is this stage's shamt field, right-aligned; base is the weight of its LSB.
   function automatic logic [MAX_XLEN-1:0] shift_stage(input logic [MAX_XLEN-1:0] data,
                                                       input logic [5:0]          amt_bits,
                                                       input int unsigned         base,
                                                       input logic                dir,
                                                       input logic                arith);
      logic [5:0]                 sh;
      logic signed [MAX_XLEN-1:0] sdata;
      sh    = amt_bits << base;
      sdata = data;
      if (!dir) begin
         return data << sh;
      end else if (arith) begin
         return sdata >>> sh;
      end else begin
         return data >> sh;
      end
   endfunction

endpackage

// File: rtl/shift_pipe_stage_reg.sv
// One valid/ready register of the shift pipeline: applies this stage's shamt field,
// then registers the partial result with op, shamt and tag.
module shift_stage_reg
   import shift_pipe_pkg::*;
#(
   parameter int unsigned XLEN  = 64,
   parameter int unsigned TAG_W = 5,
   parameter int unsigned STAGE = 0,
   parameter int unsigned BPS   = 3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [2:0]               in_op,
   input  logic [XLEN-1:0]          in_data,
   input  logic [$clog2(XLEN)-1:0]  in_shamt,
   input  logic [TAG_W-1:0]         in_tag,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [2:0]               out_op,
   output logic [XLEN-1:0]          out_data,
   output logic [$clog2(XLEN)-1:0]  out_shamt,
   output logic [TAG_W-1:0]         out_tag
);

   localparam int unsigned SHAMT_W = shamt_w(XLEN);
   localparam int unsigned LO      = STAGE * BPS;
   // Field width, clipped so trailing stages past SHAMT_W shift by nothing.
   localparam int unsigned NB      = (LO >= SHAMT_W) ? 0 :
                                     ((SHAMT_W - LO < BPS) ? SHAMT_W - LO : BPS);
   localparam logic [SHAMT_W-1:0] FIELD_MASK = SHAMT_W'((64'd1 << NB) - 64'd1);

   logic                valid_q;
   logic [2:0]          op_q;
   logic [XLEN-1:0]     data_q;
   logic [SHAMT_W-1:0]  shamt_q;
   logic [TAG_W-1:0]    tag_q;

   logic                dir, arith;
   logic [SHAMT_W-1:0]  amt;
   logic [MAX_XLEN-1:0] ext, shifted;

   always_comb begin
      dir     = (in_op[1:0] != 2'b00);
      arith   = in_op[1];
      amt     = (in_shamt >> LO) & FIELD_MASK;
      ext     = arith ? MAX_XLEN'($signed(in_data)) : MAX_XLEN'(in_data);
      shifted = shift_stage(ext, 6'(amt), LO, dir, arith);
   end

   assign in_ready = !valid_q || out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         op_q    <= '0;
         data_q  <= '0;
         shamt_q <= '0;
         tag_q   <= '0;
      end else begin
         if (flush) begin
            valid_q <= 1'b0;
         end else if (in_ready) begin
            valid_q <= in_valid;
         end
         if (in_valid && in_ready) begin
            op_q    <= in_op;
            data_q  <= shifted[XLEN-1:0];
            shamt_q <= in_shamt;
            tag_q   <= in_tag;
         end
      end
   end

   assign out_valid = valid_q;
   assign out_op    = op_q;
   assign out_data  = data_q;
   assign out_shamt = shamt_q;
   assign out_tag   = tag_q;

endmodule

// File: rtl/shift_pipe.sv
// Pipelined RV64I shift unit (SLL/SRL/SRA and word forms) with valid/ready, flush and tag.
// Normalises operands at entry and sign-extends word results at exit.
module shift_pipe
   import shift_pipe_pkg::*;
#(
   parameter int unsigned XLEN   = 64,
   parameter int unsigned STAGES = 2,
   parameter int unsigned TAG_W  = 5
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [2:0]              in_op,
   input  logic [XLEN-1:0]         in_data,
   input  logic [$clog2(XLEN)-1:0] in_shamt,
   input  logic [TAG_W-1:0]        in_tag,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [XLEN-1:0]         out_data,
   output logic [TAG_W-1:0]        out_tag
);

   localparam int unsigned SHAMT_W = shamt_w(XLEN);
   localparam int unsigned BPS     = (SHAMT_W + STAGES - 1) / STAGES;

   logic               s_vld [STAGES];
   logic               s_rdy [STAGES];
   logic [2:0]         s_op  [STAGES];
   logic [XLEN-1:0]    s_dat [STAGES];
   logic [SHAMT_W-1:0] s_sha [STAGES];
   logic [TAG_W-1:0]   s_tag [STAGES];

   logic               legal, word;
   logic [XLEN-1:0]    norm_data, last_data;
   logic [SHAMT_W-1:0] norm_shamt;

   // Illegal codes (and word ops on a 32-bit datapath) enter as zero so they emerge as zero.
   always_comb begin
      word       = in_op[2];
      legal      = (in_op[1:0] != 2'b11) && !(word && (XLEN == 32));
      norm_data  = in_data;
      norm_shamt = in_shamt;
      if (!legal) begin
         norm_data = '0;
      end else if (word) begin
         norm_shamt[SHAMT_W-1] = 1'b0;
         if (in_op == OpSraw) begin
            norm_data = XLEN'($signed(in_data[31:0]));
         end else if (in_op == OpSrlw) begin
            norm_data = XLEN'(in_data[31:0]);
         end
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic               st_in_v, st_out_r;
      logic [2:0]         st_op;
      logic [XLEN-1:0]    st_dat;
      logic [SHAMT_W-1:0] st_sha;
      logic [TAG_W-1:0]   st_tag;

      if (k == 0) begin : g_first
         assign st_in_v = in_valid;
         assign st_op   = in_op;
         assign st_dat  = norm_data;
         assign st_sha  = norm_shamt;
         assign st_tag  = in_tag;
      end else begin : g_next
         assign st_in_v = s_vld[k-1];
         assign st_op   = s_op[k-1];
         assign st_dat  = s_dat[k-1];
         assign st_sha  = s_sha[k-1];
         assign st_tag  = s_tag[k-1];
      end

      if (k == STAGES - 1) begin : g_last
         assign st_out_r = out_ready;
      end else begin : g_mid
         assign st_out_r = s_rdy[k+1];
      end

      shift_stage_reg #(
         .XLEN  (XLEN),
         .TAG_W (TAG_W),
         .STAGE (k),
         .BPS   (BPS)
      ) u_stage (
         .clk       (clk),
         .rst_n     (rst_n),
         .flush     (flush),
         .in_valid  (st_in_v),
         .in_ready  (s_rdy[k]),
         .in_op     (st_op),
         .in_data   (st_dat),
         .in_shamt  (st_sha),
         .in_tag    (st_tag),
         .out_valid (s_vld[k]),
         .out_ready (st_out_r),
         .out_op    (s_op[k]),
         .out_data  (s_dat[k]),
         .out_shamt (s_sha[k]),
         .out_tag   (s_tag[k])
      );
   end

   assign in_ready  = s_rdy[0];
   assign out_valid = s_vld[STAGES-1];
   assign out_tag   = s_tag[STAGES-1];
   assign last_data = s_dat[STAGES-1];

   always_comb begin
      out_data = last_data;
      if (s_op[STAGES-1][2]) begin
         out_data = XLEN'($signed(last_data[31:0]));
      end
   end

endmodule

// File: tb/tb_shift_pipe.sv
// Directed and random checks of shift_pipe against a 64-bit reference model,
// using an in-order scoreboard filled on accept and drained on output transfer.
module tb_shift_pipe;
   import shift_pipe_pkg::*;

   localparam int unsigned XLEN   = 64;
   localparam int unsigned STAGES = 2;
   localparam int unsigned TAG_W  = 5;

   typedef struct packed {
      logic [63:0]      data;
      logic [TAG_W-1:0] tag;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             flush = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [2:0]       in_op = '0;
   logic [63:0]      in_data = '0;
   logic [5:0]       in_shamt = '0;
   logic [TAG_W-1:0] in_tag = '0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [63:0]      out_data;
   logic [TAG_W-1:0] out_tag;

   logic [63:0]      cur_exp = '0;
   exp_t             sb [$];
   int               n_checks = 0;
   int               n_fail = 0;

   logic             held = 1'b0;
   logic [63:0]      held_data = '0;
   logic [TAG_W-1:0] held_tag = '0;

   shift_pipe #(
      .XLEN   (XLEN),
      .STAGES (STAGES),
      .TAG_W  (TAG_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_data   (in_data),
      .in_shamt  (in_shamt),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_tag   (out_tag)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] want);
      n_checks++;
      assert (obs === want) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", name, obs, want);
      end
   endtask

   function automatic logic [63:0] model(input logic [2:0] op, input logic [63:0] d,
                                         input logic [5:0] sh);
      logic signed [63:0] sd;
      logic signed [31:0] sw;
      logic [31:0]        w;
      sd = d;
      sw = d[31:0];
      w  = '0;
      case (op)
         3'd0: return d << sh;
         3'd1: return d >> sh;
         3'd2: return sd >>> sh;
         3'd4: w = d[31:0] << sh[4:0];
         3'd5: w = d[31:0] >> sh[4:0];
         3'd6: w = sw >>> sh[4:0];
         default: return 64'd0;
      endcase
      return {{32{w[31]}}, w};
   endfunction

   // Output monitor: in-order scoreboard plus stability while stalled.
   always @(negedge clk) begin
      if (!rst_n) begin
         held <= 1'b0;
      end else begin
         if (held && out_valid) begin
            check("hold_data", out_data, held_data);
            check("hold_tag", 64'(out_tag), 64'(held_tag));
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_out", 64'(out_valid), 64'd0);
            end else begin
               check("out_data", out_data, sb[0].data);
               check("out_tag", 64'(out_tag), 64'(sb[0].tag));
               sb.delete(0);
            end
         end
         held      <= out_valid && !out_ready;
         held_data <= out_data;
         held_tag  <= out_tag;
      end
   end

   task automatic drive(input logic [2:0] op, input logic [63:0] d, input logic [5:0] sh,
                        input logic [TAG_W-1:0] tag, input logic [63:0] want);
      in_op    = op;
      in_data  = d;
      in_shamt = sh;
      in_tag   = tag;
      cur_exp  = want;
      in_valid = 1'b1;
   endtask

   // Called at a negedge: records whether the current request will be accepted.
   task automatic take(output bit acc);
      acc = in_valid && in_ready && !flush;
      if (flush) sb.delete();
      if (acc) sb.push_back('{data: cur_exp, tag: in_tag});
   endtask

   task automatic step(output bit acc);
      @(negedge clk);
      take(acc);
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [2:0] op, input logic [63:0] d, input logic [5:0] sh,
                       input logic [TAG_W-1:0] tag, input logic [63:0] want);
      bit acc;
      acc = 1'b0;
      drive(op, d, sh, tag, want);
      for (int i = 0; i < 50 && !acc; i++) step(acc);
      check("send_accept", 64'(acc), 64'd1);
      in_valid = 1'b0;
   endtask

   task automatic send_timed(input logic [2:0] op, input logic [63:0] d, input logic [5:0] sh,
                             input logic [TAG_W-1:0] tag, input logic [63:0] want);
      int lat;
      bit got;
      send(op, d, sh, tag, want);
      lat = 1;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (out_valid) begin
            got = 1'b1;
         end else begin
            @(posedge clk);
            lat++;
         end
      end
      check("latency_seen", 64'(got), 64'd1);
      check("latency", 64'(lat), 64'(STAGES));
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 50 && sb.size() != 0; i++) begin
         @(posedge clk);
         #1;
      end
      check(name, 64'(sb.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          acc;
      int          n_acc;
      int          n_sent;
      logic [2:0]  rop;
      logic [63:0] rd;
      logic [5:0]  rsh;

      // Reset values, then in_ready on the first cycle after release
      #12;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data", out_data, 64'd0);
      check("rst_out_tag", 64'(out_tag), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;

      // shamt=0 on a negative SRA operand, with latency measurement
      send_timed(OpSra, 64'h8000_0000_0000_0000, 6'd0, 5'd1, 64'h8000_0000_0000_0000);

      // Directed op patterns
      send(OpSraw, 64'h0000_0000_8000_0010, 6'd4, 5'd2, 64'hFFFF_FFFF_F800_0001);
      send(OpSrlw, 64'h0000_0000_8000_0010, 6'd4, 5'd3, 64'h0000_0000_0800_0001);
      send(OpSllw, 64'h0000_0000_4000_0001, 6'b100001, 5'd4, 64'hFFFF_FFFF_8000_0002);
      send(OpSll, 64'h1, 6'd63, 5'd5, 64'h8000_0000_0000_0000);
      send(OpSrl, 64'hFFFF_FFFF_FFFF_FFFF, 6'd63, 5'd6, 64'h1);
      send(OpSra, 64'h8000_0000_0000_0000, 6'd63, 5'd7, 64'hFFFF_FFFF_FFFF_FFFF);
      send(OpSra, 64'h8000_0000_0000_0000, 6'd36, 5'd8, 64'hFFFF_FFFF_F800_0000);
      send(OpSrlw, 64'h1234_5678_8000_0000, 6'd0, 5'd9, 64'hFFFF_FFFF_8000_0000);
      send(3'd3, 64'hDEAD_BEEF_0123_4567, 6'd5, 5'd10, 64'd0);
      send(3'd7, 64'hDEAD_BEEF_0123_4567, 6'd5, 5'd11, 64'd0);
      drain("directed_drain");

      // Backpressure: fill with out_ready low, then release
      out_ready = 1'b0;
      n_acc = 0;
      drive(OpSll, 64'd1, 6'd4, 5'd1, 64'h10);
      for (int i = 0; i < 4; i++) begin
         step(acc);
         check("bp_in_ready", 64'(acc), 64'(n_acc < int'(STAGES)));
         if (acc) begin
            n_acc++;
            drive(OpSll, 64'(n_acc + 1), 6'd4, TAG_W'(n_acc + 1), 64'(n_acc + 1) << 4);
         end
      end
      check("bp_stall_valid", 64'(out_valid), 64'd1);
      check("bp_stall_tag", 64'(out_tag), 64'd1);
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("bp_drain_valid", 64'(out_valid), 64'd1);
         check("bp_drain_tag", 64'(out_tag), 64'(k + 1));
         take(acc);
         @(posedge clk);
         #1;
         if (acc) begin
            n_acc++;
            if (n_acc < 4) begin
               drive(OpSll, 64'(n_acc + 1), 6'd4, TAG_W'(n_acc + 1), 64'(n_acc + 1) << 4);
            end else begin
               in_valid = 1'b0;
            end
         end
      end
      drain("bp_drain");

      // Flush with two ops in flight and a new request presented
      out_ready = 1'b0;
      send(OpSll, 64'hAA, 6'd1, 5'd11, 64'h154);
      send(OpSrl, 64'hAA, 6'd1, 5'd12, 64'h55);
      drive(OpSll, 64'h3, 6'd2, 5'd13, 64'hC);
      flush = 1'b1;
      step(acc);
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("flush_no_valid", 64'(out_valid), 64'd0);
         @(posedge clk);
         #1;
      end
      send_timed(OpSrl, 64'hF0, 6'd4, 5'd14, 64'hF);
      drain("flush_drain");

      // Asynchronous reset mid-stream
      out_ready = 1'b0;
      send(OpSll, 64'h5, 6'd1, 5'd20, 64'hA);
      send(OpSll, 64'h6, 6'd1, 5'd21, 64'hC);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_out_valid", 64'(out_valid), 64'd0);
      check("arst_out_data", out_data, 64'd0);
      check("arst_out_tag", 64'(out_tag), 64'd0);
      sb.delete();
      #7;
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("arst_no_valid", 64'(out_valid), 64'd0);
         check("arst_in_ready", 64'(in_ready), 64'd1);
         @(posedge clk);
         #1;
      end

      // Random regression against the reference model
      n_sent = 0;
      for (int cyc = 0; cyc < 40000 && n_sent < 10000; cyc++) begin
         if (!in_valid && $urandom_range(0, 3) != 0) begin
            rop = 3'($urandom_range(0, 7));
            rd  = {$urandom(), $urandom()};
            rsh = 6'($urandom_range(0, 63));
            drive(rop, rd, rsh, TAG_W'(n_sent), model(rop, rd, rsh));
         end
         out_ready = ($urandom_range(0, 3) != 0);
         step(acc);
         if (acc) begin
            n_sent++;
            in_valid = 1'b0;
         end
      end
      check("rand_count", 64'(n_sent), 64'd10000);
      drain("rand_drain");
      @(negedge clk);
      check("final_idle", 64'(out_valid), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
